// File: rtl/spi_speed_ramp_pkg.sv
// Shared definitions for the SPI motor-speed ramp requester and the
// downstream register map: FSM states, speed type, register address.
package spi_speed_ramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WAIT   = 2'd3
  } ramp_state_e;

  typedef logic signed [15:0] speed_t;

  // Motor-speed register address, shared with the downstream register map.
  localparam logic [15:0] DEFAULT_SPEED_ADDR = 16'h0000;

  // Sign-extend a speed to 17 bits so differences never overflow.
  function automatic logic [16:0] sext17(input speed_t v);
    return {v[15], v};
  endfunction

endpackage

// File: rtl/spi_speed_ramp_step.sv
// Combinational next-speed calculator: moves current toward target by at
// most STEP, landing exactly on target when it is within reach.
module spi_speed_ramp_step
  import spi_speed_ramp_pkg::*;
#(
  parameter logic [15:0] STEP = 16'd64
) (
  input  speed_t i_target,
  input  speed_t i_current,
  output speed_t o_next
);

  logic [16:0] diff_s;
  logic [16:0] mag_s;

  // 17-bit difference and its magnitude select between snap and step.
  always_comb begin
    diff_s = sext17(i_target) - sext17(i_current);
    if (diff_s[16]) begin
      mag_s = 17'd0 - diff_s;
    end else begin
      mag_s = diff_s;
    end
    if (mag_s <= {1'b0, STEP}) begin
      o_next = i_target;
    end else if (diff_s[16]) begin
      // |diff| > STEP, so the result lies strictly between current and target.
      o_next = i_current - STEP;
    end else begin
      o_next = i_current + STEP;
    end
  end

endmodule

// File: rtl/spi_speed_ramp.sv
// APB requester that ramps the downstream motor-speed register toward a
// target in bounded steps separated by a programmable dwell.
module spi_speed_ramp
  import spi_speed_ramp_pkg::*;
#(
  parameter logic [15:0] STEP          = 16'd64,
  parameter logic [15:0] STEP_INTERVAL = 16'd2000,
  parameter logic [15:0] SPEED_ADDR    = DEFAULT_SPEED_ADDR,
  parameter logic [7:0]  APB_TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_target_valid,
  input  logic [15:0] i_target,
  output logic        o_busy,
  output logic        o_at_target,
  output logic [15:0] o_current,
  output logic        o_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [15:0] PADDR,
  output logic [15:0] PWDATA,
  input  logic        PREADY,
  input  logic [15:0] PRDATA
);

  ramp_state_e state_q, state_d;
  speed_t      target_q, target_d;
  speed_t      current_q, current_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [15:0] paddr_q, paddr_d;
  logic [15:0] pwdata_q, pwdata_d;
  logic        err_q, err_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [15:0] iv_cnt_q, iv_cnt_d;

  speed_t      next_s;
  logic [16:0] iv_next_s;

  // Read data is never used by a write-only requester; it is folded into
  // an otherwise unused net so it cannot reach any logic.
  logic unused_prdata_s;
  assign unused_prdata_s = ^PRDATA;

  spi_speed_ramp_step #(
    .STEP(STEP)
  ) u_step (
    .i_target (target_q),
    .i_current(current_q),
    .o_next   (next_s)
  );

  assign iv_next_s = {1'b0, iv_cnt_q} + 17'd1;

  // Next-state logic for the ramp FSM, APB signals and dwell/timeout counters.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    current_d = current_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    err_d     = 1'b0;
    to_cnt_d  = to_cnt_q;
    iv_cnt_d  = iv_cnt_q;

    if (i_target_valid) begin
      target_d = i_target;
    end else begin
      target_d = target_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (target_q != current_q) begin
          pwdata_d = next_s;
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = SPEED_ADDR;
          state_d  = ST_SETUP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        to_cnt_d  = 8'd0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          current_d = pwdata_q;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          iv_cnt_d  = 16'd0;
          if (pwdata_q != target_q) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (to_cnt_q >= (APB_TIMEOUT - 8'd1)) begin
          // Abandon the stalled write; the dwell then retries the same step.
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          err_d     = 1'b1;
          iv_cnt_d  = 16'd0;
          state_d   = ST_WAIT;
        end else begin
          to_cnt_d  = to_cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        // A zero interval still spends exactly one cycle here.
        if (iv_next_s >= {1'b0, STEP_INTERVAL}) begin
          if (target_q != current_q) begin
            pwdata_d = next_s;
            psel_d   = 1'b1;
            pwrite_d = 1'b1;
            paddr_d  = SPEED_ADDR;
            state_d  = ST_SETUP;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          iv_cnt_d = iv_next_s[15:0];
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= 16'sd0;
      current_q <= 16'sd0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 16'h0000;
      pwdata_q  <= 16'h0000;
      err_q     <= 1'b0;
      to_cnt_q  <= 8'd0;
      iv_cnt_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      current_q <= current_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      iv_cnt_q  <= iv_cnt_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign o_err       = err_q;
  assign o_current   = current_q;
  assign o_busy      = (state_q != ST_IDLE) || (target_q != current_q);
  assign o_at_target = !o_busy;

endmodule

// File: tb/tb_spi_speed_ramp.sv
// Directed self-checking bench for spi_speed_ramp and its step calculator.
module tb_spi_speed_ramp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_target_valid = 1'b0;
  logic [15:0] i_target = 16'h0000;
  logic        PREADY = 1'b1;
  logic [15:0] PRDATA = 16'hA5A5;
  logic        o_busy, o_at_target, o_err;
  logic [15:0] o_current;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR, PWDATA;

  logic [15:0] u_tgt = 16'h0000;
  logic [15:0] u_cur = 16'h0000;
  logic [15:0] u_next;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;

  spi_speed_ramp dut (
    .clk(clk), .rst(rst), .i_target_valid(i_target_valid), .i_target(i_target),
    .o_busy(o_busy), .o_at_target(o_at_target), .o_current(o_current), .o_err(o_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  spi_speed_ramp_step #(.STEP(16'd64)) u_step (
    .i_target(u_tgt), .i_current(u_cur), .o_next(u_next)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (o_err === 1'b1) err_cnt <= err_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; i_target_valid = 1'b0; i_target = 16'h0000; PREADY = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_target(input logic [15:0] t);
    @(negedge clk);
    i_target = t; i_target_valid = 1'b1;
    @(negedge clk);
    i_target_valid = 1'b0;
  endtask

  // Waits for a completed APB write; also records the SETUP cycle before it.
  task automatic wait_hs(input int budget, output bit ok, output logic [15:0] data,
                         output int hs_cyc, output int setup_cyc);
    ok = 1'b0; data = 16'h0000; hs_cyc = -1; setup_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (PSEL && !PENABLE) setup_cyc = cyc;
      if (PSEL && PENABLE && PREADY) begin
        data = PWDATA; hs_cyc = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit saw_psel;
    do_reset();
    n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin
      n_fail++; $display("FAIL reset_apb_ctrl: got %b%b%b required 000", PSEL, PENABLE, PWRITE); end
    n_checks++; if (PADDR !== 16'h0000 || PWDATA !== 16'h0000) begin
      n_fail++; $display("FAIL reset_apb_bus: got %h/%h required 0000/0000", PADDR, PWDATA); end
    n_checks++; if (o_err !== 1'b0 || o_busy !== 1'b0 || o_at_target !== 1'b1) begin
      n_fail++; $display("FAIL reset_status: err/busy/at got %b%b%b required 001", o_err, o_busy, o_at_target); end
    n_checks++; if (o_current !== 16'h0000) begin
      n_fail++; $display("FAIL reset_current: got %h required 0000", o_current); end
    saw_psel = 1'b0;
    repeat (20) begin @(negedge clk); if (PSEL !== 1'b0) saw_psel = 1'b1; end
    n_checks++; if (saw_psel) begin
      n_fail++; $display("FAIL reset_no_write: got PSEL activity required none"); end
  endtask

  task automatic test_ramp_up();
    logic [15:0] exp_w [4] = '{16'd64, 16'd128, 16'd192, 16'd200};
    bit ok; logic [15:0] d; int hc, sc, prev_hc;
    prev_hc = -1;
    set_target(16'd200);
    for (int k = 0; k < 4; k++) begin
      wait_hs(3000, ok, d, hc, sc);
      n_checks++; if (!ok || d !== exp_w[k]) begin
        n_fail++; $display("FAIL up_write%0d: got %h (ok=%0d) required %h", k, d, ok, exp_w[k]); end
      n_checks++; if (PWRITE !== 1'b1 || PADDR !== 16'h0000) begin
        n_fail++; $display("FAIL up_addr%0d: got pwrite=%b paddr=%h required 1/0000", k, PWRITE, PADDR); end
      if (k > 0) begin
        n_checks++; if (sc - prev_hc !== 2001) begin
          n_fail++; $display("FAIL up_dwell%0d: got %0d required 2001", k, sc - prev_hc); end
      end
      if (k < 3) begin
        n_checks++; if (o_busy !== 1'b1 || o_at_target !== 1'b0) begin
          n_fail++; $display("FAIL up_busy%0d: got busy=%b at=%b required 1/0", k, o_busy, o_at_target); end
      end
      prev_hc = hc;
    end
    @(negedge clk);
    n_checks++; if (o_current !== 16'd200 || o_at_target !== 1'b1 || PSEL !== 1'b0) begin
      n_fail++; $display("FAIL up_final: got cur=%h at=%b psel=%b required 00c8/1/0", o_current, o_at_target, PSEL); end
  endtask

  task automatic test_ramp_down();
    logic [15:0] exp_w [5] = '{16'd136, 16'd72, 16'd8, 16'hFFC8, 16'hFF9C};
    bit ok; logic [15:0] d; int hc, sc;
    set_target(16'hFF9C);
    for (int k = 0; k < 5; k++) begin
      wait_hs(3000, ok, d, hc, sc);
      n_checks++; if (!ok || d !== exp_w[k]) begin
        n_fail++; $display("FAIL down_write%0d: got %h (ok=%0d) required %h", k, d, ok, exp_w[k]); end
      @(negedge clk);
      n_checks++; if (o_current !== exp_w[k]) begin
        n_fail++; $display("FAIL down_current%0d: got %h required %h", k, o_current, exp_w[k]); end
    end
    n_checks++; if (o_at_target !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL down_at_target: got at=%b busy=%b required 1/0", o_at_target, o_busy); end
  endtask

  task automatic test_step_unit();
    logic [15:0] tv [8] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'hFF9C, 16'h0040, 16'h0041, 16'hFFBF, 16'h0000};
    logic [15:0] cv [8] = '{16'h7FC0, 16'h8000, 16'h7FFF, 16'hFFC8, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] ev [8] = '{16'h7FFF, 16'h8040, 16'h7FBF, 16'hFF9C, 16'h0040, 16'h0040, 16'hFFC0, 16'h0000};
    for (int k = 0; k < 8; k++) begin
      u_tgt = tv[k]; u_cur = cv[k];
      #1;
      n_checks++; if (u_next !== ev[k]) begin
        n_fail++; $display("FAIL step_vec%0d: t=%h c=%h got %h required %h", k, tv[k], cv[k], u_next, ev[k]); end
    end
  endtask

  task automatic test_timeout();
    int acc, last, err_base, setup_c, acc2;
    bit seen_err, ok; logic [15:0] d; int hc, sc;
    do_reset();
    err_base = err_cnt;
    PREADY = 1'b0;
    set_target(16'd100);
    acc = 0; last = -1; seen_err = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE) begin acc++; last = cyc; end
      else if (acc > 0) begin seen_err = (o_err === 1'b1); break; end
    end
    n_checks++; if (acc !== 255) begin
      n_fail++; $display("FAIL to_access_len: got %0d required 255", acc); end
    n_checks++; if (!seen_err || PSEL !== 1'b0) begin
      n_fail++; $display("FAIL to_err_pulse: got err=%0d psel=%b required 1/0", seen_err, PSEL); end
    n_checks++; if (o_current !== 16'h0000 || PWDATA !== 16'd64) begin
      n_fail++; $display("FAIL to_hold: got cur=%h pwdata=%h required 0000/0040", o_current, PWDATA); end
    @(negedge clk);
    n_checks++; if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL to_err_width: got %b required 0", o_err); end
    setup_c = -1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (PSEL && !PENABLE) begin setup_c = cyc; break; end
    end
    n_checks++; if (setup_c - last !== 2001 || PWDATA !== 16'd64) begin
      n_fail++; $display("FAIL to_retry: got gap=%0d data=%h required 2001/0040", setup_c - last, PWDATA); end
    acc2 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE) acc2++;
      if (acc2 == 4) begin PREADY = 1'b1; break; end
    end
    n_checks++; if (acc2 !== 4 || PWDATA !== 16'd64) begin
      n_fail++; $display("FAIL to_late_ready: got acc=%0d data=%h required 4/0040", acc2, PWDATA); end
    @(negedge clk);
    n_checks++; if (o_current !== 16'd64 || PSEL !== 1'b0) begin
      n_fail++; $display("FAIL to_accept: got cur=%h psel=%b required 0040/0", o_current, PSEL); end
    wait_hs(3000, ok, d, hc, sc);
    n_checks++; if (!ok || d !== 16'd100) begin
      n_fail++; $display("FAIL to_next: got %h (ok=%0d) required 0064", d, ok); end
    @(negedge clk);
    n_checks++; if (err_cnt - err_base !== 1) begin
      n_fail++; $display("FAIL to_err_count: got %0d required 1", err_cnt - err_base); end
  endtask

  task automatic test_retarget();
    bit ok, in_acc; logic [15:0] d; int hc, sc;
    do_reset();
    set_target(16'd500);
    wait_hs(3000, ok, d, hc, sc);
    n_checks++; if (!ok || d !== 16'd64) begin
      n_fail++; $display("FAIL rt_first: got %h (ok=%0d) required 0040", d, ok); end
    @(negedge clk);
    PREADY = 1'b0;
    in_acc = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE) begin in_acc = 1'b1; break; end
    end
    i_target = 16'd50; i_target_valid = 1'b1;
    @(negedge clk);
    i_target_valid = 1'b0;
    n_checks++; if (!in_acc || PWDATA !== 16'd128 || PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      n_fail++; $display("FAIL rt_inflight: got acc=%0d data=%h required 1/0080", in_acc, PWDATA); end
    PREADY = 1'b1;
    @(negedge clk);
    n_checks++; if (o_current !== 16'd128) begin
      n_fail++; $display("FAIL rt_complete: got %h required 0080", o_current); end
    wait_hs(3000, ok, d, hc, sc);
    n_checks++; if (!ok || d !== 16'd64) begin
      n_fail++; $display("FAIL rt_back: got %h (ok=%0d) required 0040", d, ok); end
    wait_hs(3000, ok, d, hc, sc);
    n_checks++; if (!ok || d !== 16'd50) begin
      n_fail++; $display("FAIL rt_land: got %h (ok=%0d) required 0032", d, ok); end
    @(negedge clk);
    n_checks++; if (o_at_target !== 1'b1 || o_current !== 16'd50) begin
      n_fail++; $display("FAIL rt_final: got at=%b cur=%h required 1/0032", o_at_target, o_current); end
  endtask

  task automatic test_reset_mid();
    bit in_acc, saw_psel;
    do_reset();
    @(negedge clk);
    PREADY = 1'b0;
    set_target(16'd200);
    in_acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE) begin in_acc = 1'b1; break; end
    end
    @(negedge clk);
    n_checks++; if (!in_acc || PSEL !== 1'b1 || PENABLE !== 1'b1 || PWDATA !== 16'd64) begin
      n_fail++; $display("FAIL rm_second_access: got acc=%0d psel=%b en=%b required 1/1/1", in_acc, PSEL, PENABLE); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      n_fail++; $display("FAIL rm_drop: got psel=%b en=%b required 0/0", PSEL, PENABLE); end
    n_checks++; if (o_current !== 16'h0000 || o_busy !== 1'b0 || o_at_target !== 1'b1) begin
      n_fail++; $display("FAIL rm_state: got cur=%h busy=%b at=%b required 0000/0/1", o_current, o_busy, o_at_target); end
    rst = 1'b0; PREADY = 1'b1;
    saw_psel = 1'b0;
    repeat (2500) begin @(negedge clk); if (PSEL !== 1'b0) saw_psel = 1'b1; end
    n_checks++; if (saw_psel || o_current !== 16'h0000) begin
      n_fail++; $display("FAIL rm_quiet: got activity=%0d cur=%h required 0/0000", saw_psel, o_current); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_step_unit();
    test_timeout();
    test_retarget();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_speed_ramp.md
Name: spi_speed_ramp

Overview:
APB requester that sits directly upstream of the SPI motor-control top level and drives its APB completer port. It accepts a target motor speed and steps the motor-speed register toward it. Each step is one APB write of bounded size, and steps are separated by a programmable dwell. The PMD901 therefore never sees a speed jump larger than STEP per update.

Parameters:
STEP, 16'd64, maximum magnitude of change per APB write (unsigned, must be non-zero)
STEP_INTERVAL, 16'd2000, clk cycles between the end of one write and the SETUP phase of the next
SPEED_ADDR, 16'h0000, APB address of the motor-speed register
APB_TIMEOUT, 8'd255, ACCESS-phase cycles with PREADY low before the transfer is aborted

Ports:
clk  input  1  system clock, same domain as the downstream PCLK
rst  input  1  synchronous reset, active-high
i_target_valid  input  1  pulse or level; when high, i_target is latched as the new target
i_target  input  16  signed target speed
o_busy  output  1  high whenever current speed differs from target or an APB transfer is in flight
o_at_target  output  1  high when current speed equals target and the FSM is IDLE
o_current  output  16  signed speed last successfully written over APB
o_err  output  1  one-cycle pulse on APB timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction; always 1 when PSEL is high
PADDR  output  16  APB address; equals SPEED_ADDR during a transfer
PWDATA  output  16  APB write data
PREADY  input  1  APB completer ready
PRDATA  input  16  unused; must not be connected to any internal logic

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM=IDLE; target=0; current=0; PSEL, PENABLE, PWRITE, o_err, o_busy = 0; PADDR=0; PWDATA=0; o_at_target=1.
  - No APB write is issued at reset.
  - Reset asserted mid-transfer drops PSEL/PENABLE at that same edge; the partial write is abandoned and current stays 0.
- Target latch:
  - i_target_valid is accepted in every state (no backpressure); the register updates the cycle after.
  - A target change during SETUP/ACCESS does not alter the in-flight PWDATA; it takes effect at the next step computation.
- Step arithmetic:
  - diff = target - current, computed sign-extended to 17 bits (no overflow).
  - If |diff| <= STEP: next = target; otherwise next = current + STEP or current - STEP, per the sign of diff.
  - next is always inside the 16-bit signed range; no wrap.
- FSM states and transitions:
  - IDLE: if target != current, register next into PWDATA and go to SETUP; otherwise stay.
  - SETUP (one cycle): PSEL=1, PENABLE=0, PWRITE=1, PADDR=SPEED_ADDR. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1: current <= PWDATA; drop PSEL/PENABLE next cycle. Go to WAIT if the new current != target, else IDLE.
    - PREADY=0 for APB_TIMEOUT consecutive cycles: drop PSEL/PENABLE, pulse o_err, leave current unchanged, go to WAIT (retry).
  - WAIT: count STEP_INTERVAL cycles.
    - On expiry, if target != current, recompute next, load PWDATA, go to SETUP; otherwise go to IDLE.
    - A target change during WAIT does not restart the counter.
- Output timing:
  - o_busy = (FSM != IDLE) || (target != current).
  - o_at_target = !o_busy.
- STEP_INTERVAL=0: WAIT lasts exactly one cycle.

Decomposition:
- Shared package spi_pkg: FSM state enum (IDLE, SETUP, ACCESS, WAIT), 16-bit speed typedef, default SPEED_ADDR constant. The downstream register map uses the same constant.
- One natural sub-module: spi_ramp_step, a combinational next-speed calculator (target, current, STEP -> next). It is unit-tested separately.
- The timeout counter and interval counter stay inline.

Test Plan:
- Reset, then target=+200, completer always ready -> writes 64, 128, 192, 200; SETUP edges 2000 cycles apart from each end of ACCESS; o_at_target rises after the write of 200.
- current=200, target=-100 -> writes 136, 72, 8, -56, -100; no value ever wraps.
- target=0x7FFF from current=0x7FC0 (diff 63 <= STEP) -> single write 0x7FFF; the 17-bit diff path shows no overflow.
- Completer holds PREADY low for 255 cycles on the first write -> o_err pulses once, current stays 0, the same value is rewritten after 2000 cycles. Then PREADY=1 after 3 cycles -> write accepted.
- Target changed from 500 to 50 during ACCESS of the write of 128 -> 128 completes; next write is 64, then 50.
- rst asserted on the 2nd ACCESS cycle of the write of 64 -> PSEL/PENABLE low at that edge, current=0, target=0, and no further APB activity.
